// File: rtl/acesso_memoria_if.sv
// Pipeline <-> memory-access bus. The slave side is the access unit; the
// master side is the pipeline plus the MEM block that returns read data.
interface acesso_memoria_if;
  logic        requisicao;
  logic        escrever;
  logic [31:0] endereco;
  logic [31:0] dado;
  logic        ocupado;
  logic        pronto;
  logic [31:0] dadoLido;
  logic        erroAlinhamento;
  logic [31:0] memEndereco;
  logic [31:0] memValor;
  logic        escreverMemoria;
  logic        lerMemoria;
  logic [31:0] saida;

  modport slave (
    input  requisicao, escrever, endereco, dado, saida,
    output ocupado, pronto, dadoLido, erroAlinhamento,
           memEndereco, memValor, escreverMemoria, lerMemoria
  );

  modport master (
    output requisicao, escrever, endereco, dado, saida,
    input  ocupado, pronto, dadoLido, erroAlinhamento,
           memEndereco, memValor, escreverMemoria, lerMemoria
  );
endinterface

// File: rtl/acesso_memoria.sv
// Memory access unit: accepts aligned load/store requests, holds the MEM
// strobe for LATENCIA cycles, then pulses pronto. Misaligned requests are
// rejected with a one-cycle erroAlinhamento pulse.
module acesso_memoria #(
  parameter int LATENCIA = 2
) (
  input logic             clock,
  input logic             reset,
  acesso_memoria_if.slave bus
);
  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] ACESSO    = 2'd1;
  localparam logic [1:0] CONCLUIDO = 2'd2;

  // Counter preload: reaching 0 marks the last strobe cycle.
  localparam logic [3:0] CARGA = 4'(LATENCIA - 1);

  logic [1:0]  estado;
  logic [3:0]  contador;
  logic        tipo;     // latched escrever: 1 = store
  logic [31:0] mem_end;
  logic [31:0] mem_val;
  logic [31:0] lido;
  logic        erro;

  // Control FSM plus request latches and load-result register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      contador <= 4'd0;
      tipo     <= 1'b0;
      mem_end  <= 32'd0;
      mem_val  <= 32'd0;
      lido     <= 32'd0;
      erro     <= 1'b0;
    end else begin
      erro <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.requisicao) begin
            if (bus.endereco[1:0] == 2'b00) begin
              mem_end  <= bus.endereco;
              mem_val  <= bus.dado;
              tipo     <= bus.escrever;
              contador <= CARGA;
              estado   <= ACESSO;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        ACESSO: begin
          if (contador == 4'd0) begin
            estado <= CONCLUIDO;
            if (!tipo) lido <= bus.saida;
          end else begin
            contador <= contador - 4'd1;
          end
        end
        CONCLUIDO: estado <= OCIOSO;
        default:   estado <= OCIOSO;
      endcase
    end
  end

  // Outputs decode from state so reset drops strobes without a clock edge.
  assign bus.ocupado         = (estado == ACESSO);
  assign bus.escreverMemoria = (estado == ACESSO) &&  tipo;
  assign bus.lerMemoria      = (estado == ACESSO) && !tipo;
  assign bus.pronto          = (estado == CONCLUIDO);
  assign bus.erroAlinhamento = erro;
  assign bus.memEndereco     = mem_end;
  assign bus.memValor        = mem_val;
  assign bus.dadoLido        = lido;
endmodule

// File: tb/tb_acesso_memoria.sv
// Bench for acesso_memoria: scoreboard of expected accesses, monitor that
// pops on pronto/erroAlinhamento, plus width checks at LATENCIA 1 and 15.
module tb_acesso_memoria;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  acesso_memoria_if b2 ();
  acesso_memoria_if b1 ();
  acesso_memoria_if b15 ();

  acesso_memoria #(.LATENCIA(2))  dut2  (.clock(clock), .reset(reset), .bus(b2.slave));
  acesso_memoria #(.LATENCIA(1))  dut1  (.clock(clock), .reset(reset), .bus(b1.slave));
  acesso_memoria #(.LATENCIA(15)) dut15 (.clock(clock), .reset(reset), .bus(b15.slave));

  // MEM block model: 64 words, combinational read, write on strobe
  logic [31:0] mem [0:63] = '{default: 32'd0};
  always_comb b2.saida = mem[b2.memEndereco[7:2]];
  always @(posedge clock) if (b2.escreverMemoria) mem[b2.memEndereco[7:2]] <= b2.memValor;
  assign b1.saida  = 32'hA5A5_0001;
  assign b15.saida = 32'hA5A5_0001;

  typedef struct {
    bit          err;
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] lido;
    int          n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:63] = '{default: 32'd0};
  logic [31:0] model_lido = 32'd0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic idle(int k);
    repeat (k) begin
      b2.requisicao = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  // Present one request; returns once the next request may be sampled.
  task automatic issue(bit st, logic [31:0] a, logic [31:0] d, bit hold);
    exp_t e;
    b2.requisicao = 1'b1;
    b2.escrever   = st;
    b2.endereco   = a;
    b2.dado       = d;
    e.err  = (a[1:0] != 2'b00);
    e.st   = st;
    e.addr = a;
    e.data = d;
    e.n    = cyc + 1;
    if (!e.err) begin
      if (st) ref_mem[a[7:2]] = d;
      else    model_lido = ref_mem[a[7:2]];
    end
    e.lido = model_lido;
    sb.push_back(e);
    @(posedge clock); #1;
    if (!e.err) begin
      repeat (LAT + 1) begin
        b2.requisicao = hold ? 1'b1 : 1'($urandom);
        b2.escrever   = 1'($urandom);
        b2.endereco   = $urandom;
        b2.dado       = $urandom;
        @(posedge clock); #1;
      end
    end
  endtask

  // Monitor for the LATENCIA=2 instance
  int          run = 0;
  int          first = 0;
  logic [31:0] s_addr, s_val, exp_lido;
  logic        s_st;
  exp_t        e;
  always @(negedge clock) begin
    if (!reset) begin
      run = 0;
      exp_lido = 32'd0;
    end else begin
      check("strobe_exclusive", 32'(b2.escreverMemoria & b2.lerMemoria), 32'd0);
      check("pronto_erro_exclusive", 32'(b2.pronto & b2.erroAlinhamento), 32'd0);
      check("ocupado", 32'(b2.ocupado), 32'(b2.escreverMemoria | b2.lerMemoria));
      if (b2.escreverMemoria | b2.lerMemoria) begin
        if (run == 0) begin
          check("strobe_expected", 32'(sb.size() != 0), 32'd1);
          first  = cyc;
          s_addr = b2.memEndereco;
          s_val  = b2.memValor;
          s_st   = b2.escreverMemoria;
        end else begin
          check("addr_stable", b2.memEndereco, s_addr);
          check("val_stable", b2.memValor, s_val);
        end
        run++;
      end
      if (b2.pronto) begin
        if (sb.size() == 0) check("pronto_expected", 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          check("kind_pronto", 32'(e.err), 32'd0);
          check("strobe_width", 32'(run), 32'(LAT));
          check("strobe_start", 32'(first), 32'(e.n));
          check("pronto_cycle", 32'(cyc), 32'(e.n + LAT));
          check("mem_addr", s_addr, e.addr);
          check("strobe_type", 32'(s_st), 32'(e.st));
          if (e.st) check("mem_val", s_val, e.data);
          check("dadoLido", b2.dadoLido, e.lido);
          exp_lido = e.lido;
        end
        run = 0;
      end else if (b2.erroAlinhamento) begin
        if (sb.size() == 0) check("erro_expected", 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          check("kind_erro", 32'(e.err), 32'd1);
          check("erro_cycle", 32'(cyc), 32'(e.n));
          check("erro_no_strobe", 32'(b2.escreverMemoria | b2.lerMemoria), 32'd0);
        end
      end else begin
        check("dadoLido_hold", b2.dadoLido, exp_lido);
      end
    end
  end

  // Monitor for LATENCIA 1 and 15 instances
  int  sw [2] = '{0, 0};
  int  sf [2] = '{0, 0};
  int  npr [2] = '{0, 0};
  int  lat_v [2] = '{1, 15};
  int  n_small = 0;
  bit  ld_small = 1'b0;
  logic [1:0] stb_s, pr_s;
  logic [31:0] lido_s [2];
  always @(negedge clock) begin
    stb_s = {b15.escreverMemoria | b15.lerMemoria, b1.escreverMemoria | b1.lerMemoria};
    pr_s  = {b15.pronto, b1.pronto};
    lido_s[0] = b1.dadoLido;
    lido_s[1] = b15.dadoLido;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (stb_s[i]) begin
          if (sw[i] == 0) sf[i] = cyc;
          sw[i]++;
        end
        if (pr_s[i]) begin
          check($sformatf("width_L%0d", lat_v[i]), 32'(sw[i]), 32'(lat_v[i]));
          check($sformatf("start_L%0d", lat_v[i]), 32'(sf[i]), 32'(n_small));
          check($sformatf("pronto_L%0d", lat_v[i]), 32'(cyc), 32'(n_small + lat_v[i]));
          check($sformatf("lido_L%0d", lat_v[i]), lido_s[i], ld_small ? 32'hA5A5_0001 : 32'd0);
          sw[i] = 0;
          npr[i]++;
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    b2.requisicao = 1'b0; b2.escrever = 1'b0; b2.endereco = 32'd0; b2.dado = 32'd0;
    b1.requisicao = 1'b0; b1.escrever = 1'b0; b1.endereco = 32'd0; b1.dado = 32'd0;
    b15.requisicao = 1'b0; b15.escrever = 1'b0; b15.endereco = 32'd0; b15.dado = 32'd0;
    @(posedge clock); #1;
    check("rst_ocupado", 32'(b2.ocupado), 32'd0);
    check("rst_pronto", 32'(b2.pronto), 32'd0);
    check("rst_dadoLido", b2.dadoLido, 32'd0);
    check("rst_erro", 32'(b2.erroAlinhamento), 32'd0);
    check("rst_memEndereco", b2.memEndereco, 32'd0);
    check("rst_memValor", b2.memValor, 32'd0);
    check("rst_strobes", 32'({b2.escreverMemoria, b2.lerMemoria}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle(2);

    // Directed: store, load, misaligned, back-to-back with requisicao held
    issue(1'b1, 32'd4, 32'd100, 1'b0);
    idle(1);
    issue(1'b0, 32'd4, 32'd0, 1'b0);
    idle(1);
    issue(1'b0, 32'd6, 32'd0, 1'b0);
    idle(2);
    issue(1'b1, 32'd8, 32'd11, 1'b1);
    issue(1'b1, 32'd12, 32'd22, 1'b1);
    idle(1);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(1'($urandom), a, $urandom, 1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end

    // Reset abort during first ACESSO cycle of a load
    issue(1'b1, 32'd16, 32'h1234_5678, 1'b0);
    issue(1'b0, 32'd16, 32'd0, 1'b0);
    idle(2);
    check("pre_reset_lido", b2.dadoLido, 32'h1234_5678);
    b2.requisicao = 1'b1; b2.escrever = 1'b0; b2.endereco = 32'd16;
    @(posedge clock); #1;
    b2.requisicao = 1'b0;
    check("abort_strobe_before", 32'(b2.lerMemoria), 32'd1);
    #1 reset = 1'b0;
    #1;
    model_lido = 32'd0;
    check("abort_ler", 32'(b2.lerMemoria), 32'd0);
    check("abort_ocupado", 32'(b2.ocupado), 32'd0);
    check("abort_lido", b2.dadoLido, 32'd0);
    check("abort_memEndereco", b2.memEndereco, 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
      check("abort_no_pronto", 32'(b2.pronto), 32'd0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    issue(1'b0, 32'd16, 32'd0, 1'b0);
    idle(3);

    // LATENCIA 1 and 15: store then load on both
    for (int k = 0; k < 2; k++) begin
      b1.requisicao = 1'b1;  b1.escrever = (k == 0);  b1.endereco = 32'h10;  b1.dado = 32'h55;
      b15.requisicao = 1'b1; b15.escrever = (k == 0); b15.endereco = 32'h10; b15.dado = 32'h55;
      n_small  = cyc + 1;
      ld_small = (k == 1);
      @(posedge clock); #1;
      b1.requisicao = 1'b0; b15.requisicao = 1'b0;
      repeat (20) begin
        b1.endereco = $urandom; b15.dado = $urandom;
        @(posedge clock); #1;
      end
    end
    check("prontos_L1", 32'(npr[0]), 32'd2);
    check("prontos_L15", 32'(npr[1]), 32'd2);

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
